cic_comb_cascade: RTL

- Parametrised comb section for the CIC decimator: NS cascaded comb stages, each computing y[n] = x[n] - x[n-DM] on the decimated-rate stream.
- Supports NCH time-interleaved channels tagged by i_ch; each channel keeps its own per-stage delay history.
- Sits after the integrator cascade and decimator, ahead of gain compensation; successor to the single-stage comb, adding stage count, channels, a history clear and a pipelined valid.

---
 rtl/cic_comb_cascade.sv | 113 +++++++++++
 1 files changed

// File: rtl/cic_comb_cascade.sv
// CIC decimator comb section: NS cascaded y[n] = x[n] - x[n-DM] stages, each
// keeping an independent delay history per time-interleaved channel.
module cic_comb_cascade #(
  parameter int  IW  = 16,
  parameter int  OW  = 24,
  parameter int  NS  = 3,
  parameter int  DM  = 2,
  parameter int  NCH = 2,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [CW-1:0]        i_ch,
  input  logic signed [IW-1:0] i_data,
  input  logic                 i_clear,
  output logic                 o_valid,
  output logic [CW-1:0]        o_ch,
  output logic signed [OW-1:0] o_data
);

  if (OW < IW) begin : g_chk_ow
    $fatal(1, "cic_comb_cascade: OW must be >= IW");
  end
  if (NS < 1) begin : g_chk_ns
    $fatal(1, "cic_comb_cascade: NS must be >= 1");
  end
  if (DM < 1) begin : g_chk_dm
    $fatal(1, "cic_comb_cascade: DM must be >= 1");
  end
  if (NCH < 1) begin : g_chk_nch
    $fatal(1, "cic_comb_cascade: NCH must be >= 1");
  end

  logic [NS-1:0]        vld_q;
  logic [CW-1:0]        ch_q    [NS];
  logic signed [OW-1:0] data_q  [NS];
  logic signed [OW-1:0] hist_q  [NS][NCH][DM];

  logic                 accept;
  logic [NS-1:0]        in_vld;
  logic [CW-1:0]        in_ch   [NS];
  logic signed [OW-1:0] in_data [NS];
  logic signed [OW-1:0] dly     [NS];
  logic signed [OW-1:0] data_d  [NS];

  // Out-of-range tags are dropped here so they never touch any history.
  assign accept = i_ce && !i_clear && (32'(i_ch) < NCH);

  always_comb begin
    in_vld = '0;
    for (int k = 0; k < NS; k++) begin
      in_ch[k]   = '0;
      in_data[k] = '0;
      dly[k]     = '0;
      data_d[k]  = '0;
    end
    for (int k = 0; k < NS; k++) begin
      int p;
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        in_vld[k]  = accept;
        in_ch[k]   = i_ch;
        in_data[k] = OW'(i_data);
      end else begin
        in_vld[k]  = vld_q[p];
        in_ch[k]   = ch_q[p];
        in_data[k] = data_q[p];
      end
      for (int c = 0; c < NCH; c++) begin
        if (in_ch[k] == CW'(c)) dly[k] = hist_q[k][c][DM-1];
      end
      data_d[k] = in_data[k] - dly[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q <= '0;
      for (int k = 0; k < NS; k++) begin
        ch_q[k]   <= '0;
        data_q[k] <= '0;
        for (int c = 0; c < NCH; c++)
          for (int d = 0; d < DM; d++) hist_q[k][c][d] <= '0;
      end
    end else if (i_clear) begin
      // Output data is left holding; only valids and histories are flushed.
      vld_q <= '0;
      for (int k = 0; k < NS; k++)
        for (int c = 0; c < NCH; c++)
          for (int d = 0; d < DM; d++) hist_q[k][c][d] <= '0;
    end else begin
      vld_q <= in_vld;
      for (int k = 0; k < NS; k++) begin
        if (in_vld[k]) begin
          ch_q[k]   <= in_ch[k];
          data_q[k] <= data_d[k];
          for (int c = 0; c < NCH; c++) begin
            if (in_ch[k] == CW'(c)) begin
              hist_q[k][c][0] <= in_data[k];
              for (int d = 1; d < DM; d++) hist_q[k][c][d] <= hist_q[k][c][d-1];
            end
          end
        end
      end
    end
  end

  assign o_valid = vld_q[NS-1];
  assign o_ch    = ch_q[NS-1];
  assign o_data  = data_q[NS-1];

endmodule
